ram_bubble_sorter: RTL and testbench
====================================

# ram_bubble_sorter

Sort-engine controller that acts as the initiator side of the single-port synchronous-read RAM. It sorts the whole RAM into ascending unsigned order in place using bubble sort with early exit. It issues reads, compares adjacent words and writes back swapped pairs. It sits between the top-level control (start/done) and the RAM port.

## Interface
- ADDR_WDTH, 4, RAM address width; RAM depth N = 2**ADDR_WDTH words.
- DATA_WDTH, 32, word width; words are compared as unsigned.

- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  sort request, sampled in IDLE only
- busy  out  1  high while sort in progress
- done  out  1  one-cycle pulse when sort complete
- mem_rd_enable  out  1  RAM read strobe
- mem_wr_enable  out  1  RAM write strobe
- mem_address  out  ADDR_WDTH  RAM address
- mem_wr_data  out  DATA_WDTH  RAM write data
- mem_rd_data  in  DATA_WDTH  RAM read data, registered in RAM, valid the cycle after the rd strobe

## Operation
- States: IDLE, RD_A, RD_B, CMP, WR_A, WR_B, NEXT-decision folded into CMP/WR_B, DONE.
- Registers:
  - idx: pair index, ADDR_WDTH bits.
  - limit: pairs in the current pass, ADDR_WDTH bits.
  - a_reg, b_reg: DATA_WDTH bits.
  - swapped: 1 bit.
- IDLE: when start=1, load idx=0, limit=N-1 and swapped=0, then go to RD_A.
- RD_A: mem_rd_enable=1, mem_address=idx. Go to RD_B.
- RD_B: mem_rd_enable=1, mem_address=idx+1. Latch a_reg<=mem_rd_data. Go to CMP.
- CMP: no memory access. Latch b_reg<=mem_rd_data.
  - If mem_rd_data < a_reg (strict), go to WR_A.
  - Otherwise advance.
- WR_A: mem_wr_enable=1, mem_address=idx, mem_wr_data=b_reg. Set swapped=1. Go to WR_B.
- WR_B: mem_wr_enable=1, mem_address=idx+1, mem_wr_data=a_reg. Advance.
- Advance:
  - If idx != limit-1: idx++, go to RD_A.
  - Otherwise (end of pass):
    - If swapped (including the swap just made) is 0, or limit == 1, go to DONE.
    - Else limit--, idx=0, swapped=0, go to RD_A.
- DONE: done=1, busy=0. Go to IDLE.
- Equal words are never swapped, so the sort is stable and no writes are issued for equal pairs.
- mem_address arithmetic: idx+1 never wraps, because idx ≤ N-2.
- Exactly one of the strobes is high in RD_A, RD_B, WR_A and WR_B. Both strobes are low in all other states.
- start while busy or in DONE is ignored.

## Timing
- Reset (async): state=IDLE; busy, done, strobes, mem_address and mem_wr_data all 0; internal registers 0.
- Outputs are Moore decodes of registered state and counters. They are valid for the whole state cycle.
- busy=1 in every state except IDLE and DONE.
- The first RD_A is the cycle after the start-sampling edge.
- Per compare: 3 cycles without a swap, 5 cycles with a swap.
- done pulses the cycle after the last compare/write cycle. In the idle state after DONE, done=0.
- Reset mid-sort: the FSM aborts immediately and no further writes occur. The RAM holds a partially sorted permutation (never a torn pair beyond a WR_A without its WR_B).

## Structure
- Shared package sort_pkg: state encoding localparams (IDLE..DONE) and the default ADDR_WDTH/DATA_WDTH constants, reused by future sort blocks.
- One optional sub-module, sort_cmp: combinational unsigned a>b compare, DATA_WDTH-parameterized.
- RAM is not instantiated inside. The bench connects ram_bubble_sorter to the existing sync-read RAM.

## Test plan
- RAM preloaded 0..15 ascending, start pulse:
  - No mem_wr_enable ever.
  - done exactly 45 cycles after the first RD_A (one pass, 15×3).
  - RAM unchanged.
- RAM preloaded 15..0 descending:
  - 120 write pairs.
  - done after 600 compare cycles (limits 15..1, all swaps).
  - RAM is 0..15.
- RAM all 0x0000_0007: single pass, zero writes, done after 45 cycles.
- Random 32-bit values including 0xFFFF_FFFF and 0: final RAM ascending unsigned, and a permutation of the input.
- start held high through the sort and re-pulsed mid-sort:
  - Single sort only; no restart.
  - After DONE, start still high triggers a new (already-sorted, 45-cycle) run.
- rst_n asserted during WR_A of the first swap:
  - Outputs zero the same cycle; state IDLE.
  - A subsequent start completes and leaves RAM sorted.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared definitions for the RAM sort engines: default widths and FSM state encoding.
package sort_pkg;

    localparam int unsigned DefAddrWdth = 4;
    localparam int unsigned DefDataWdth = 32;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRdA  = 3'd1,
        StRdB  = 3'd2,
        StCmp  = 3'd3,
        StWrA  = 3'd4,
        StWrB  = 3'd5,
        StDone = 3'd6
    } sort_state_e;

endpackage

// File: rtl/ram_bubble_sorter_if.sv
// Single-port synchronous-read RAM port; the sorter is the master, the RAM the slave.
interface ram_bubble_sorter_if
    import sort_pkg::*;
#(
    parameter int unsigned ADDR_WDTH = DefAddrWdth,
    parameter int unsigned DATA_WDTH = DefDataWdth
);
    logic                 mem_rd_enable;
    logic                 mem_wr_enable;
    logic [ADDR_WDTH-1:0] mem_address;
    logic [DATA_WDTH-1:0] mem_wr_data;
    logic [DATA_WDTH-1:0] mem_rd_data;

    modport master (
        output mem_rd_enable,
        output mem_wr_enable,
        output mem_address,
        output mem_wr_data,
        input  mem_rd_data
    );

    modport slave (
        input  mem_rd_enable,
        input  mem_wr_enable,
        input  mem_address,
        input  mem_wr_data,
        output mem_rd_data
    );
endinterface

// File: rtl/sort_cmp.sv
// Unsigned magnitude compare: gt is high when a is strictly greater than b.
module sort_cmp #(
    parameter int unsigned DATA_WDTH = 32
) (
    input  logic [DATA_WDTH-1:0] a,
    input  logic [DATA_WDTH-1:0] b,
    output logic                 gt
);
    assign gt = (a > b);
endmodule

// File: rtl/ram_bubble_sorter.sv
// In-place ascending bubble sort of a sync-read RAM, with early exit on a swap-free pass.
module ram_bubble_sorter
    import sort_pkg::*;
#(
    parameter int unsigned ADDR_WDTH = DefAddrWdth,
    parameter int unsigned DATA_WDTH = DefDataWdth
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    ram_bubble_sorter_if.master mem
);
    localparam logic [ADDR_WDTH-1:0] OneIdx = {{(ADDR_WDTH-1){1'b0}}, 1'b1};

    sort_state_e          state_q, state_d;
    logic [ADDR_WDTH-1:0] idx_q, idx_d;
    logic [ADDR_WDTH-1:0] limit_q, limit_d;
    logic [DATA_WDTH-1:0] a_q, a_d;
    logic [DATA_WDTH-1:0] b_q, b_d;
    logic                 swapped_q, swapped_d;
    logic                 advance;
    logic                 a_gt_b;

    // a_q holds word[idx]; the read data in CMP is word[idx+1].
    sort_cmp #(
        .DATA_WDTH(DATA_WDTH)
    ) u_cmp (
        .a  (a_q),
        .b  (mem.mem_rd_data),
        .gt (a_gt_b)
    );

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            limit_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            swapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            limit_q   <= limit_d;
            a_q       <= a_d;
            b_q       <= b_d;
            swapped_q <= swapped_d;
        end
    end

    // Next-state logic and Moore decode of the RAM strobes and status outputs.
    always_comb begin
        state_d           = state_q;
        idx_d             = idx_q;
        limit_d           = limit_q;
        a_d               = a_q;
        b_d               = b_q;
        swapped_d         = swapped_q;
        advance           = 1'b0;
        busy              = 1'b0;
        done              = 1'b0;
        mem.mem_rd_enable = 1'b0;
        mem.mem_wr_enable = 1'b0;
        mem.mem_address   = '0;
        mem.mem_wr_data   = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    idx_d     = '0;
                    limit_d   = '1;
                    swapped_d = 1'b0;
                    state_d   = StRdA;
                end
            end
            StRdA: begin
                busy              = 1'b1;
                mem.mem_rd_enable = 1'b1;
                mem.mem_address   = idx_q;
                state_d           = StRdB;
            end
            StRdB: begin
                busy              = 1'b1;
                mem.mem_rd_enable = 1'b1;
                mem.mem_address   = idx_q + OneIdx;
                a_d               = mem.mem_rd_data;
                state_d           = StCmp;
            end
            StCmp: begin
                busy = 1'b1;
                b_d  = mem.mem_rd_data;
                if (a_gt_b) begin
                    state_d = StWrA;
                end else begin
                    advance = 1'b1;
                end
            end
            StWrA: begin
                busy              = 1'b1;
                mem.mem_wr_enable = 1'b1;
                mem.mem_address   = idx_q;
                mem.mem_wr_data   = b_q;
                swapped_d         = 1'b1;
                state_d           = StWrB;
            end
            StWrB: begin
                busy              = 1'b1;
                mem.mem_wr_enable = 1'b1;
                mem.mem_address   = idx_q + OneIdx;
                mem.mem_wr_data   = a_q;
                advance           = 1'b1;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Step to the next pair, or close the pass; swapped_q already includes a WR_A swap.
        if (advance) begin
            if (idx_q != limit_q - OneIdx) begin
                idx_d   = idx_q + OneIdx;
                state_d = StRdA;
            end else if (!swapped_q || (limit_q == OneIdx)) begin
                state_d = StDone;
            end else begin
                limit_d   = limit_q - OneIdx;
                idx_d     = '0;
                swapped_d = 1'b0;
                state_d   = StRdA;
            end
        end
    end
endmodule

// File: tb/tb_ram_bubble_sorter.sv
// Bench for ram_bubble_sorter: sync-read RAM model plus a plain-array bubble-sort reference.
module tb_ram_bubble_sorter;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int N  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;

    ram_bubble_sorter_if #(.ADDR_WDTH(AW), .DATA_WDTH(DW)) mem_if ();

    ram_bubble_sorter #(
        .ADDR_WDTH(AW),
        .DATA_WDTH(DW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy),
        .done  (done),
        .mem   (mem_if.master)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram      [N];
    logic [DW-1:0] init_img [N];
    logic [DW-1:0] exp_img  [N];
    logic [DW-1:0] snap     [N];
    logic          load = 1'b0;
    int            exp_cycles;
    int            exp_writes;
    int            tests = 0;
    int            fails = 0;
    int            clashes = 0;
    int            cyc;
    int            wrs;

    // Sync-read RAM with a bulk preload port for the bench.
    always @(posedge clk) begin
        if (load) begin
            ram <= init_img;
        end else if (mem_if.mem_wr_enable) begin
            ram[mem_if.mem_address] <= mem_if.mem_wr_data;
        end
        if (mem_if.mem_rd_enable) begin
            mem_if.mem_rd_data <= ram[mem_if.mem_address];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: early-exit bubble sort on init_img, 3 cycles per compare, +2 per swap.
    task automatic compute_model();
        logic [DW-1:0] a [N];
        logic [DW-1:0] t;
        bit            sw;
        a          = init_img;
        exp_cycles = 0;
        exp_writes = 0;
        for (int lim = N - 1; lim >= 1; lim--) begin
            sw = 1'b0;
            for (int i = 0; i < lim; i++) begin
                exp_cycles += 3;
                if (a[i+1] < a[i]) begin
                    t          = a[i];
                    a[i]       = a[i+1];
                    a[i+1]     = t;
                    exp_cycles += 2;
                    exp_writes += 2;
                    sw         = 1'b1;
                end
            end
            if (!sw) break;
        end
        exp_img = a;
    endtask

    task automatic preload();
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        compute_model();
    endtask

    task automatic check_ram(input string tag);
        int bad = 0;
        for (int i = 0; i < N; i++) begin
            if (ram[i] !== exp_img[i]) bad++;
        end
        check(tag, bad, 0);
    endtask

    // Called at the first RD_A negedge; runs until done, returning cycles and write strobes.
    task automatic wait_done(input string tag, input bit repulse, output int c, output int w);
        bit got = 1'b0;
        c = 0;
        w = 0;
        while (!got && c < 3000) begin
            if (mem_if.mem_wr_enable) w++;
            if (mem_if.mem_wr_enable && mem_if.mem_rd_enable) clashes++;
            if (repulse && c == 20) start = 1'b0;
            if (repulse && c == 22) start = 1'b1;
            @(negedge clk);
            c++;
            if (done) got = 1'b1;
        end
        check({tag, " done seen"}, got, 1);
        check({tag, " cycles"}, c, exp_cycles);
        check({tag, " writes"}, w, exp_writes);
        check({tag, " busy at done"}, busy, 0);
    endtask

    task automatic check_first_rd(input string tag);
        check({tag, " first RD_A"},
              {busy, mem_if.mem_rd_enable, mem_if.mem_wr_enable, mem_if.mem_address},
              {1'b1, 1'b1, 1'b0, 4'd0});
    endtask

    task automatic run_sort(input string tag, output int c, output int w);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_first_rd(tag);
        wait_done(tag, 1'b0, c, w);
        @(negedge clk);
        check({tag, " idle after done"}, {done, busy}, 2'b00);
        check_ram({tag, " ram"});
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("reset outputs",
              {busy, done, mem_if.mem_rd_enable, mem_if.mem_wr_enable,
               mem_if.mem_address, mem_if.mem_wr_data}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Already ascending: one pass, no writes.
        for (int i = 0; i < N; i++) init_img[i] = DW'(i);
        preload();
        run_sort("ascending", cyc, wrs);
        check("ascending 45 cycles", cyc, 45);
        check("ascending no writes", wrs, 0);

        // Descending: every compare swaps across all passes.
        for (int i = 0; i < N; i++) init_img[i] = DW'(N - 1 - i);
        preload();
        run_sort("descending", cyc, wrs);
        check("descending 600 cycles", cyc, 600);
        check("descending 120 pairs", wrs, 240);

        // All equal: never swapped.
        for (int i = 0; i < N; i++) init_img[i] = 32'h0000_0007;
        preload();
        run_sort("all equal", cyc, wrs);
        check("all equal 45 cycles", cyc, 45);
        check("all equal no writes", wrs, 0);

        // Random full-range words with the extremes injected; last run has many duplicates.
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < N; i++) begin
                init_img[i] = (r == 4) ? DW'($urandom_range(0, 5)) : $urandom();
            end
            init_img[$urandom_range(0, N - 1)] = 32'hFFFF_FFFF;
            init_img[$urandom_range(0, N - 1)] = 32'h0000_0000;
            preload();
            run_sort($sformatf("random%0d", r), cyc, wrs);
        end

        // start held high and re-pulsed mid-sort: one sort, then a fresh run after DONE.
        for (int i = 0; i < N; i++) init_img[i] = $urandom();
        preload();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check_first_rd("held");
        wait_done("held", 1'b1, cyc, wrs);
        check_ram("held ram");
        @(negedge clk);
        check("held idle after done", {done, busy}, 2'b00);
        @(negedge clk);
        check_first_rd("held rerun");
        start    = 1'b0;
        init_img = exp_img;
        compute_model();
        wait_done("held rerun", 1'b0, cyc, wrs);
        check("held rerun 45 cycles", cyc, 45);
        check_ram("held rerun ram");

        // Reset during the first WR_A: no write lands, then a clean re-sort.
        for (int i = 0; i < N; i++) init_img[i] = $urandom();
        init_img[1] = init_img[0] + 32'd1;
        init_img[0] = init_img[0] + 32'd2;
        preload();
        snap = exp_img;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!mem_if.mem_wr_enable && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("reset wr_a reached", mem_if.mem_wr_enable, 1);
        #1 rst_n = 1'b0;
        #1;
        check("reset mid-sort outputs",
              {busy, done, mem_if.mem_rd_enable, mem_if.mem_wr_enable,
               mem_if.mem_address, mem_if.mem_wr_data}, 0);
        @(negedge clk);
        begin
            int bad = 0;
            for (int i = 0; i < N; i++) if (ram[i] !== init_img[i]) bad++;
            check("reset no write", bad, 0);
        end
        rst_n = 1'b1;
        check("reset stays idle", busy, 0);
        init_img = ram;
        compute_model();
        run_sort("after reset", cyc, wrs);
        begin
            int bad = 0;
            for (int i = 0; i < N; i++) if (ram[i] !== snap[i]) bad++;
            check("after reset sorted original", bad, 0);
        end

        check("strobe exclusivity", clashes, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
